fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_if.sv | 41 ++++
 rtl/fifo_mem.sv | 36 +++
 rtl/fifo_param.sv | 134 +++++++++++++
 tb/tb_fifo_param.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helpers for the parameterised FWFT FIFO.
//   FIFO_DATA_W  : default data word width
//   FIFO_DEPTH   : default number of entries (power of two, >= 2)
//   level_width(): bits needed to hold an occupancy of 0..depth
//   lvl_op_e     : per-cycle occupancy action, encoded as {push, pop}
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 9;
    localparam int unsigned FIFO_DEPTH  = 16;

    // The level must represent DEPTH itself, so one bit wider than a pointer.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_POP  = 2'b01,
        LVL_PUSH = 2'b10,
        LVL_BOTH = 2'b11
    } lvl_op_e;

endpackage

// File: rtl/fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if
// Push/pop handshake and status bundle for fifo_param.
//   master : producer/consumer side, drives write/data_in/read/clr_err
//   slave  : FIFO side, drives data_out, status flags, level, error flags
// ---------------------------------------------------------------------------
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
);

    localparam int unsigned LVL_W = level_width(DEPTH);

    logic              write;
    logic [DATA_W-1:0] data_in;
    logic              read;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              dav;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport master (
        output write, data_in, read, clr_err,
        input  data_out, dav, full, almost_full, almost_empty, level,
               overflow, underflow
    );

    modport slave (
        input  write, data_in, read, clr_err,
        output data_out, dav, full, almost_full, almost_empty, level,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Storage array for fifo_param. Not reset.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address (write pointer)
//   wdata : write data
//   raddr : read address (read pointer)
//   rdata : asynchronous read data at raddr
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read gives first-word-fall-through at the FIFO head.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parameterised first-word-fall-through FIFO with sticky error flags.
//   clk      : clock, rising edge
//   reset_b  : asynchronous active-low reset (clears pointers, level, flags)
//   bus      : fifo_if.slave
//     write/data_in  push request and data
//     read           pop request
//     clr_err        clears overflow/underflow (a same-cycle error wins)
//     data_out       head word while dav=1, zero otherwise
//     dav/full/almost_full/almost_empty  decoded from registered level
//     level          occupancy 0..DEPTH
//     overflow       sticky: push rejected while full
//     underflow      sticky: pop requested while empty
// ---------------------------------------------------------------------------
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = FIFO_DATA_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic  clk,
    input  logic  reset_b,
    fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              dav;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              udf_set;
    logic [DATA_W-1:0] head;
    lvl_op_e           lvl_op;

    // Status decoded only from the registered level.
    assign full = (level == LVL_W'(DEPTH));
    assign dav  = (level != '0);

    // A push into a full FIFO is accepted when a pop frees the head slot at
    // the same edge; full implies dav, so that pop is always accepted too.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (bus.write) begin
            if (!full || bus.read) begin
                push_ok = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (bus.read) begin
            if (dav) begin
                pop_ok = 1'b1;
            end else begin
                udf_set = 1'b1;
            end
        end
    end

    assign lvl_op = lvl_op_e'({push_ok, pop_ok});

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case (lvl_op)
                LVL_PUSH: level <= level + LVL_W'(1);
                LVL_POP:  level <= level - LVL_W'(1);
                default:  level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.data_out     = dav ? head : '0;
    assign bus.dav          = dav;
    assign bus.full         = full;
    assign bus.almost_full  = (level >= LVL_W'(AF_THRESH));
    assign bus.almost_empty = (level <= LVL_W'(AE_THRESH));
    assign bus.level        = level;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Directed bench for fifo_param with DATA_W=9, DEPTH=4 (AF_THRESH=2,
// AE_THRESH=2). Inputs change 1ns after the rising edge; outputs are
// checked at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_fifo_param;

    logic clk;
    logic reset_b;
    int   n_tests;
    int   n_fail;

    fifo_if #(.DATA_W(9), .DEPTH(4)) bus ();

    fifo_param #(.DATA_W(9), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Level, head word and the four decoded status flags in one go.
    task automatic chk_state(input string tag, input int lvl, input int dout,
                             input int dv, input int fl, input int af, input int ae);
        chk({tag, ".level"}, 32'(bus.level), 32'(lvl));
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(dout));
        chk({tag, ".dav"}, 32'(bus.dav), 32'(dv));
        chk({tag, ".full"}, 32'(bus.full), 32'(fl));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    endtask

    task automatic chk_err(input string tag, input int ovf, input int udf);
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(udf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset_b      = 1'b0;
        bus.write    = 1'b0;
        bus.read     = 1'b0;
        bus.clr_err  = 1'b0;
        bus.data_in  = '0;

        // Reset state
        #1;
        chk_state("rst", 0, 0, 0, 0, 0, 1);
        chk_err("rst", 0, 0);
        tick();
        tick();
        reset_b = 1'b1;

        // Fill 0x001..0x004
        bus.write = 1'b1;
        bus.data_in = 9'h001; tick(); chk_state("fill1", 1, 9'h001, 1, 0, 0, 1);
        bus.data_in = 9'h002; tick(); chk_state("fill2", 2, 9'h001, 1, 0, 1, 1);
        bus.data_in = 9'h003; tick(); chk_state("fill3", 3, 9'h001, 1, 0, 1, 0);
        bus.data_in = 9'h004; tick(); chk_state("fill4", 4, 9'h001, 1, 1, 1, 0);
        chk_err("fill4", 0, 0);

        // Overflow: 0x1FF dropped
        bus.data_in = 9'h1FF; tick();
        chk_state("ovf", 4, 9'h001, 1, 1, 1, 0);
        chk_err("ovf", 1, 0);
        bus.write = 1'b0;

        // Drain: order 1,2,3,4 with 0x1FF absent
        bus.read = 1'b1;
        tick(); chk_state("pop1", 3, 9'h002, 1, 0, 1, 0);
        tick(); chk_state("pop2", 2, 9'h003, 1, 0, 1, 1);
        tick(); chk_state("pop3", 1, 9'h004, 1, 0, 0, 1);
        tick(); chk_state("pop4", 0, 0, 0, 0, 0, 1);
        chk_err("pop4", 1, 0);
        bus.read = 1'b0;

        // Clear the sticky overflow
        bus.clr_err = 1'b1; tick();
        chk_err("clr1", 0, 0);
        bus.clr_err = 1'b0;

        // Refill, then push+pop while full
        bus.write = 1'b1;
        bus.data_in = 9'h001; tick();
        bus.data_in = 9'h002; tick();
        bus.data_in = 9'h003; tick();
        bus.data_in = 9'h004; tick();
        chk_state("refill", 4, 9'h001, 1, 1, 1, 0);
        bus.data_in = 9'h0AA; bus.read = 1'b1; tick();
        chk_state("fullsim", 4, 9'h002, 1, 1, 1, 0);
        chk_err("fullsim", 0, 0);
        bus.write = 1'b0;
        tick(); chk_state("dr1", 3, 9'h003, 1, 0, 1, 0);
        tick(); chk_state("dr2", 2, 9'h004, 1, 0, 1, 1);
        tick(); chk_state("dr3", 1, 9'h0AA, 1, 0, 0, 1);
        tick(); chk_state("dr4", 0, 0, 0, 0, 0, 1);
        chk_err("dr4", 0, 0);

        // Underflow with simultaneous write on empty
        bus.write = 1'b1; bus.data_in = 9'h055; tick();
        chk_state("udf", 1, 9'h055, 1, 0, 0, 1);
        chk_err("udf", 0, 1);
        bus.read = 1'b0;

        // Fill to full, then clr_err together with a new overflow
        bus.data_in = 9'h010; tick();
        bus.data_in = 9'h011; tick();
        bus.data_in = 9'h012; tick();
        chk_state("fill_b", 4, 9'h055, 1, 1, 1, 0);
        bus.data_in = 9'h1FF; bus.clr_err = 1'b1; tick();
        chk_state("clr_ovf", 4, 9'h055, 1, 1, 1, 0);
        chk_err("clr_ovf", 1, 0);
        bus.write = 1'b0; tick();
        chk_err("clr_only", 0, 0);
        bus.clr_err = 1'b0;

        // Reset mid-traffic
        bus.read = 1'b1; tick();
        chk_state("pre_rst", 3, 9'h010, 1, 0, 1, 0);
        bus.read = 1'b0;
        #3;
        reset_b = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0, 0, 0, 1);
        tick();
        chk_state("in_rst", 0, 0, 0, 0, 0, 1);
        reset_b = 1'b1;
        bus.write = 1'b1; bus.data_in = 9'h123; tick();
        chk_state("post_rst", 1, 9'h123, 1, 0, 0, 1);
        chk_err("post_rst", 0, 0);
        bus.write = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
